// File: rtl/mdu_sequencer_if.sv
// rtl/mdu_sequencer_if.sv - handshake, result and shared-ALU bundle for mdu_sequencer
//
// Purpose: groups every non-clock/reset signal of the multiply/divide sequencer.
// Ports (seen from the slave, i.e. the sequencer):
//   start, op[1:0], rs_val[31:0], rt_val[31:0]   in   operation launch
//   busy, done, hi[31:0], lo[31:0], div_by_zero   out  status and results
//   alu_sel[4:0], alu_a[31:0], alu_b[31:0]        out  shared ALU request
//   alu_y[31:0]                                   in   shared ALU result (same cycle)
// The master side is the pipeline/EX stage, which also owns the shared ALU.

interface mdu_sequencer_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;
    logic [4:0]  alu_sel;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;

    modport master (
        output start, op, rs_val, rt_val, alu_y,
        input  busy, done, hi, lo, div_by_zero, alu_sel, alu_a, alu_b
    );

    modport slave (
        input  start, op, rs_val, rt_val, alu_y,
        output busy, done, hi, lo, div_by_zero, alu_sel, alu_a, alu_b
    );
endinterface

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - iterative MULT/MULTU/DIV/DIVU sequencer driving the shared ALU
//
// Purpose: executes one multiply or divide into HI/LO over 35 cycles, using the
// core's shared 32-bit ALU for one ADDU/SUBU per iteration cycle.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high
//   abort  in   cancel an operation in PREP/ITER (only when MDU_ABORT_EN is defined)
//   mdu    slave modport of mdu_sequencer_if (start/op/operands, busy/done/hi/lo/
//          div_by_zero, alu_sel/alu_a/alu_b out, alu_y in)
// Optional feature macro: MDU_ABORT_EN

module mdu_sequencer #(
    parameter int ITER = 32
) (
    input  logic           clk,
    input  logic           reset,
`ifdef MDU_ABORT_EN
    input  logic           abort,
`endif
    mdu_sequencer_if.slave mdu
);

    localparam int         CW       = $clog2(ITER);
    localparam logic [4:0] ALU_NOP  = 5'b00000;
    localparam logic [4:0] ALU_ADDU = 5'b00010;
    localparam logic [4:0] ALU_SUBU = 5'b00100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Working registers. Between IDLE and PREP q_q holds raw rs and m_q holds
    // raw rt; PREP turns them into the operands each algorithm wants.
    logic [1:0]    op_q, op_d;
    logic [31:0]   acc_q, acc_d;     // multiply high half / divide remainder
    logic [31:0]   q_q, q_d;         // multiplier shifting out / quotient shifting in
    logic [31:0]   m_q, m_d;         // multiplicand / divisor
    logic [CW-1:0] cnt_q, cnt_d;
    logic          neg_quo_q, neg_quo_d;
    logic          neg_rem_q, neg_rem_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          dbz_q, dbz_d;

    logic [4:0]    alu_sel_c;
    logic [31:0]   alu_a_c;
    logic [31:0]   alu_b_c;

    logic          is_div;
    logic          is_signed;
    logic [31:0]   rs_abs;
    logic [31:0]   rt_abs;
    logic [31:0]   sh;
    logic          top;
    logic          carry;
    logic          borrow;
    logic          qbit;
    logic [63:0]   prod_neg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= 2'b00;
            acc_q     <= 32'd0;
            q_q       <= 32'd0;
            m_q       <= 32'd0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        q_d       = q_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;

        alu_sel_c = ALU_NOP;
        alu_a_c   = 32'd0;
        alu_b_c   = 32'd0;

        is_div    = op_q[1];
        is_signed = op_q[0];
        rs_abs    = (is_signed && q_q[31]) ? (~q_q + 32'd1) : q_q;
        rt_abs    = (is_signed && m_q[31]) ? (~m_q + 32'd1) : m_q;
        sh        = {acc_q[30:0], q_q[31]};
        top       = acc_q[31];
        carry     = 1'b0;
        borrow    = 1'b0;
        qbit      = 1'b0;
        prod_neg  = ~{acc_q, q_q} + 64'd1;

        case (state_q)
            S_IDLE: begin
                if (mdu.start) begin
                    op_d    = mdu.op;
                    q_d     = mdu.rs_val;
                    m_d     = mdu.rt_val;
                    acc_d   = 32'd0;
                    cnt_d   = '0;
                    state_d = S_PREP;
                end
            end

            S_PREP: begin
                neg_quo_d = is_signed & (q_q[31] ^ m_q[31]);
                neg_rem_d = is_signed & q_q[31];
                if (is_div && (m_q == 32'd0)) begin
                    // Raw (not absolute) dividend goes to HI on divide by zero.
                    hi_d    = q_q;
                    lo_d    = 32'hFFFF_FFFF;
                    dbz_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    acc_d   = 32'd0;
                    cnt_d   = '0;
                    q_d     = is_div ? rs_abs : rt_abs;
                    m_d     = is_div ? rt_abs : rs_abs;
                    state_d = S_ITER;
                end
            end

            S_ITER: begin
                if (!is_div) begin
                    // Shift-add: the ALU carry-out becomes bit 63 before the shift.
                    alu_sel_c = ALU_ADDU;
                    alu_a_c   = acc_q;
                    alu_b_c   = q_q[0] ? m_q : 32'd0;
                    carry     = (mdu.alu_y < alu_a_c);
                    acc_d     = {carry, mdu.alu_y[31:1]};
                    q_d       = {mdu.alu_y[0], q_q[31:1]};
                end else begin
                    // Restoring divide; a set top bit means the shifted remainder
                    // exceeds 32 bits and so is certainly >= the divisor.
                    alu_sel_c = ALU_SUBU;
                    alu_a_c   = sh;
                    alu_b_c   = m_q;
                    borrow    = (mdu.alu_y > alu_a_c);
                    qbit      = top | ~borrow;
                    acc_d     = qbit ? mdu.alu_y : sh;
                    q_d       = {q_q[30:0], qbit};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = S_FIXUP;
                end
            end

            S_FIXUP: begin
                if (!is_div) begin
                    {hi_d, lo_d} = neg_quo_q ? prod_neg : {acc_q, q_q};
                end else begin
                    lo_d = neg_quo_q ? (~q_q + 32'd1) : q_q;
                    hi_d = neg_rem_q ? (~acc_q + 32'd1) : acc_q;
                end
                dbz_d   = 1'b0;
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef MDU_ABORT_EN
        // Abort discards any result write scheduled for this edge.
        if (abort && ((state_q == S_PREP) || (state_q == S_ITER))) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            dbz_d   = dbz_q;
        end
`endif
    end

    assign mdu.busy        = (state_q != S_IDLE);
    assign mdu.done        = (state_q == S_DONE);
    assign mdu.hi          = hi_q;
    assign mdu.lo          = lo_q;
    assign mdu.div_by_zero = dbz_q;
    assign mdu.alu_sel     = alu_sel_c;
    assign mdu.alu_a       = alu_a_c;
    assign mdu.alu_b       = alu_b_c;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - directed vector bench for mdu_sequencer with a shared-ALU model

module tb_mdu_sequencer;

    logic clk;
    logic reset;
`ifdef MDU_ABORT_EN
    logic abort;
`endif

    mdu_sequencer_if mif ();

    mdu_sequencer dut (
        .clk   (clk),
        .reset (reset),
`ifdef MDU_ABORT_EN
        .abort (abort),
`endif
        .mdu   (mif.slave)
    );

    // Shared ALU: only ADDU and SUBU are used by the sequencer.
    assign mif.alu_y = (mif.alu_sel == 5'b00010) ? (mif.alu_a + mif.alu_b) :
                       (mif.alu_sel == 5'b00100) ? (mif.alu_a - mif.alu_b) : 32'd0;

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    int   n_applied;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Launch one operation; the start-sampling edge is edge 1 and lat tracks the
    // number of the last edge seen. Returns at the negedge where done is first
    // high, or on timeout, or right after a poked reset/abort edge.
    task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input int poke_start, input int poke_reset, input int poke_abort,
                          output int lat, output int nalu);
        logic [4:0] sel;
        sel = op[1] ? 5'b00100 : 5'b00010;
        @(negedge clk);
        mif.start  = 1'b1;
        mif.op     = op;
        mif.rs_val = rs;
        mif.rt_val = rt;
        @(negedge clk);
        mif.start  = 1'b0;
        mif.op     = 2'($urandom);
        mif.rs_val = $urandom;
        mif.rt_val = $urandom;
        lat  = 1;
        nalu = 0;
        while (!mif.done && lat < 60) begin
            if (mif.alu_sel == sel) nalu++;
            mif.start = (lat == poke_start);
            if (lat == poke_reset) begin
                reset = 1'b1;
                @(negedge clk);
                lat++;
                reset = 1'b0;
                return;
            end
            if (lat == poke_abort) begin
`ifdef MDU_ABORT_EN
                abort = 1'b1;
                @(negedge clk);
                lat++;
                abort = 1'b0;
`endif
                return;
            end
            @(negedge clk);
            lat++;
        end
        mif.start = 1'b0;
    endtask

    initial begin
        int lat;
        int nalu;
        int seen_done;
        n_applied  = 0;
        n_fail     = 0;
        clk        = 1'b0;
        reset      = 1'b1;
        mif.start  = 1'b0;
        mif.op     = 2'b00;
        mif.rs_val = 32'd0;
        mif.rt_val = 32'd0;
`ifdef MDU_ABORT_EN
        abort = 1'b0;
`endif

        //                op     rs            rt            hi            lo            dbz  lat
        vecs.push_back('{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 35});
        vecs.push_back('{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 35});
        vecs.push_back('{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35});
        vecs.push_back('{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 35});
        vecs.push_back('{2'b10, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 2});
        vecs.push_back('{2'b00, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0, 35});
        vecs.push_back('{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 35});
        vecs.push_back('{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 35});
        vecs.push_back('{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 35});
        vecs.push_back('{2'b11, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 2});
        vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 35});
        vecs.push_back('{2'b10, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 35});
        vecs.push_back('{2'b10, 32'd5,        32'd9,        32'd5,        32'd0,        1'b0, 35});

        repeat (3) @(negedge clk);
        check("reset_busy",    32'(mif.busy),        32'd0);
        check("reset_done",    32'(mif.done),        32'd0);
        check("reset_dbz",     32'(mif.div_by_zero), 32'd0);
        check("reset_hi",      mif.hi,               32'd0);
        check("reset_lo",      mif.lo,               32'd0);
        check("reset_alu_sel", 32'(mif.alu_sel),     32'd0);
        check("reset_alu_a",   mif.alu_a,            32'd0);
        check("reset_alu_b",   mif.alu_b,            32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, -1, -1, -1, lat, nalu);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_hi", i), mif.hi, vecs[i].hi);
            check($sformatf("v%0d_lo", i), mif.lo, vecs[i].lo);
            check($sformatf("v%0d_dbz", i), 32'(mif.div_by_zero), 32'(vecs[i].dbz));
            check($sformatf("v%0d_alu_cycles", i), 32'(nalu), (vecs[i].lat == 35) ? 32'd32 : 32'd0);
            @(negedge clk);
            check($sformatf("v%0d_idle_busy", i), 32'(mif.busy), 32'd0);
            check($sformatf("v%0d_hold_lo", i), mif.lo, vecs[i].lo);
            check($sformatf("v%0d_idle_alu_sel", i), 32'(mif.alu_sel), 32'd0);
        end

        // start at edge 10 of a running MULTU is ignored; start in DONE is ignored too
        run_op(2'b00, 32'd5, 32'd7, 9, -1, -1, lat, nalu);
        check("restart_latency", 32'(lat), 32'd35);
        check("restart_hi", mif.hi, 32'd0);
        check("restart_lo", mif.lo, 32'd35);
        mif.start  = 1'b1;
        mif.op     = 2'b00;
        mif.rs_val = 32'd9;
        mif.rt_val = 32'd9;
        @(negedge clk);
        mif.start = 1'b0;
        check("start_in_done_busy", 32'(mif.busy), 32'd0);
        check("start_in_done_lo", mif.lo, 32'd35);

        // reset at edge 20 of a DIV aborts and clears the results
        run_op(2'b11, 32'd100, 32'd7, -1, 19, -1, lat, nalu);
        check("midreset_edge", 32'(lat), 32'd20);
        check("midreset_busy", 32'(mif.busy), 32'd0);
        check("midreset_done", 32'(mif.done), 32'd0);
        check("midreset_hi", mif.hi, 32'd0);
        check("midreset_lo", mif.lo, 32'd0);
        check("midreset_alu_sel", 32'(mif.alu_sel), 32'd0);
        @(negedge clk);
        check("midreset_still_idle", 32'(mif.busy), 32'd0);

`ifdef MDU_ABORT_EN
        run_op(2'b00, 32'd5, 32'd5, -1, -1, -1, lat, nalu);
        check("pre_abort_lo", mif.lo, 32'd25);
        @(negedge clk);
        run_op(2'b01, 32'd3, 32'd3, -1, -1, 12, lat, nalu);
        check("abort_edge", 32'(lat), 32'd13);
        check("abort_busy", 32'(mif.busy), 32'd0);
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (mif.done) seen_done++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        check("abort_lo_kept", mif.lo, 32'd25);
        check("abort_hi_kept", mif.hi, 32'd0);
`else
        seen_done = 0;
        check("no_abort_seen_done", 32'(seen_done), 32'(mif.done));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Iterative multiply/divide unit for the pipelined MIPS core; executes MULT, MULTU, DIV and DIVU into HI/LO.
- Holds no 32-bit adder of its own. It sequences the shared 32-bit ALU one operation per cycle, driving the ALU's sel, A and B inputs and reading back its Y output.
- Sits beside EX. The hazard unit stalls the pipeline while busy is high.

Parameters:
- ITER, 32, number of shift/add or shift/subtract iterations. Equals the data width and is fixed at 32 for this core.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  launch an operation; sampled only in IDLE
- op  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- rs_val  in  32  multiplicand / dividend
- rt_val  in  32  multiplier / divisor
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; hi/lo valid from this cycle on
- hi  out  32  product[63:32] or remainder
- lo  out  32  product[31:0] or quotient
- div_by_zero  out  1  set when a divide completes with rt_val==0
- alu_sel  out  5  ALU operation: 00000 nop, 00010 ADDU, 00100 SUBU
- alu_a  out  32  ALU A operand
- alu_b  out  32  ALU B operand
- alu_y  in  32  ALU result, combinational in the same cycle

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset).
- Reset:
  - state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0.
  - alu_sel=00000, alu_a=0, alu_b=0.
  - Working registers are cleared.
  - Reset mid-operation aborts immediately; hi/lo are cleared.
- States:
  - IDLE: start=1 latches op, rs_val and rt_val, then goes to PREP. start=0 stays in IDLE.
  - PREP, 1 cycle:
    - Signed ops replace each operand with its absolute value, and record neg_q = sign(rs) XOR sign(rt) and neg_r = sign(rs).
    - Unsigned ops record neg_q=0 and neg_r=0.
    - A divide with rt==0 goes straight to DONE with hi=rs_val, lo=32'hFFFFFFFF, div_by_zero=1.
    - Otherwise clears the counter and goes to ITER.
  - ITER, ITER cycles: one ALU operation per cycle, as defined below. After the 32nd iteration, go to FIXUP.
  - FIXUP, 1 cycle:
    - Multiply: if neg_q, the 64-bit {acc,q} is replaced by its two's complement (computed locally).
    - Divide: the quotient is negated if neg_q; the remainder is negated if neg_r.
    - Writes hi/lo and clears div_by_zero. Goes to DONE.
  - DONE, 1 cycle: done=1, then goes to IDLE unconditionally.
- Multiply iteration, with acc initialised to 0, q to |rt| and m to |rs|:
  - alu_sel=ADDU, alu_a=acc, alu_b = q[0] ? m : 0.
  - carry = (alu_y < alu_a), unsigned.
  - Update {acc,q} <= {carry, alu_y, q[31:1]}.
- Divide iteration (restoring), with rem initialised to 0, q to |rs| and d to |rt|:
  - sh = {rem[30:0], q[31]}; top = rem[31].
  - alu_sel=SUBU, alu_a=sh, alu_b=d.
  - borrow = (alu_y > alu_a).
  - If top | ~borrow: rem<=alu_y and the quotient bit is 1. Else rem<=sh and the quotient bit is 0.
  - q <= {q[30:0], bit}.
- Latency:
  - Normal operation: done is high 35 clock edges after the edge that samples start.
  - Divide by zero: done is high 2 edges after that edge.
- Handshake and holding rules:
  - start outside IDLE is ignored, including start in DONE.
  - hi/lo hold their values from the FIXUP write (or the PREP write for divide by zero) until the next write.
  - op and operand inputs may change freely after start is sampled.
- ALU outputs: outside ITER, alu_sel=00000 and alu_a=alu_b=0.
- Boundaries:
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - MULT 0x80000000 * 0x80000000 gives hi=0x40000000, lo=0.

Optional Feature:
- Macro MDU_ABORT_EN.
- With the macro defined:
  - An extra input port abort (1 bit) is added.
  - abort=1 in PREP or ITER forces IDLE at the next edge.
  - hi, lo and div_by_zero are left unchanged and done is not pulsed.
  - Abort has priority over the normal transition; reset has priority over abort.
- Without the macro: no abort port exists, and an operation always runs to DONE.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> done at edge 35; hi=0xFFFFFFFE, lo=0x00000001; alu_sel=00010 on all 32 ITER cycles.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_by_zero=0; DIVU rs=100, rt=7 -> lo=14, hi=2.
- DIVU rs=0x1234, rt=0 -> done at edge 2; hi=0x1234, lo=0xFFFFFFFF, div_by_zero=1; a following MULTU 2*3 clears the flag, giving lo=6.
- Pulse start again at edge 10 of a running MULTU -> ignored, result unchanged; reset at edge 20 of a DIV -> next cycle IDLE, busy=0, hi=lo=0.
- MDU_ABORT_EN: run MULTU 5*5 to completion (lo=25), then MULT 3*3 with abort at edge 12 -> IDLE at edge 13, no done pulse, lo still 25.
